// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
// Optional signed-overflow output is enabled with macro PIPE_ADDER_OVF_EN.
package pipe_adder_pkg;

   localparam int DEFAULT_WIDTH  = 8;
   localparam int DEFAULT_STAGES = 4;

   // Degenerate stage counts fall back to one chunk so elaboration reaches the parameter check.
   function automatic int chunkWidth(input int width, input int stages);
      return (stages < 1) ? width : width / stages;
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder.
// The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dataA;
   logic [WIDTH-1:0] dataB;
   logic             carry_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry_out;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;
`endif

`ifdef PIPE_ADDER_OVF_EN
   modport master (
      output in_valid, dataA, dataB, carry_in, out_ready,
      input  in_ready, out_valid, sum, carry_out, ovf
   );
   modport slave (
      input  in_valid, dataA, dataB, carry_in, out_ready,
      output in_ready, out_valid, sum, carry_out, ovf
   );
`else
   modport master (
      output in_valid, dataA, dataB, carry_in, out_ready,
      input  in_ready, out_valid, sum, carry_out
   );
   modport slave (
      input  in_valid, dataA, dataB, carry_in, out_ready,
      output in_ready, out_valid, sum, carry_out
   );
`endif

endinterface

// File: rtl/pipe_adder_stage.sv
// One CW-bit slice of the pipelined adder: registered chunk sum, carry and valid.
module pipe_adder_stage #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          reset_L,
   input  logic          en_i,
   input  logic          valid_i,
   input  logic [CW-1:0] a_i,
   input  logic [CW-1:0] b_i,
   input  logic          carry_i,
   output logic [CW-1:0] sum_o,
   output logic          carry_o,
   output logic          valid_o
);
   logic [CW-1:0] sum_d, sum_q;
   logic          carry_d, carry_q;
   logic          valid_q;

   always_comb begin
      {carry_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
      end else if (en_i) begin
         sum_q   <= sum_d;
         carry_q <= carry_d;
         valid_q <= valid_i;
      end
   end

   assign sum_o   = sum_q;
   assign carry_o = carry_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/pipe_adder.sv
// Skewed carry-chain pipelined adder, one CW-bit chunk per stage, latency STAGES.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output bus.ovf.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int STAGES = DEFAULT_STAGES
) (
   input logic         clk,
   input logic         reset_L,
   pipe_adder_if.slave bus
);
   localparam int CW          = chunkWidth(WIDTH, STAGES);
   localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;

   if (STAGES < 1 || (WIDTH % SAFE_STAGES) != 0) begin : g_badParams
      $error("pipe_adder: STAGES must be >= 1 and divide WIDTH");
   end

   logic              advance;
   logic [STAGES-1:0] stageValid;
   logic [STAGES-1:0] stageCarry;
   logic [CW-1:0]     stageA   [STAGES];
   logic [CW-1:0]     stageB   [STAGES];
   logic [CW-1:0]     stageSum [STAGES];
   logic [WIDTH-1:0]  sumAll;

   // The whole pipeline moves as one; a full output that is not taken freezes everything.
   assign advance      = bus.out_ready || !bus.out_valid;
   assign bus.in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic validIn;
      logic carryIn;

      if (k == 0) begin : g_head
         assign stageA[k] = bus.dataA[CW-1:0];
         assign stageB[k] = bus.dataB[CW-1:0];
         assign validIn   = bus.in_valid;
         assign carryIn   = bus.carry_in;
      end else begin : g_skew
         logic [CW-1:0] skewA_q [k];
         logic [CW-1:0] skewB_q [k];

         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               for (int j = 0; j < k; j++) begin
                  skewA_q[j] <= '0;
                  skewB_q[j] <= '0;
               end
            end else if (advance) begin
               skewA_q[0] <= bus.dataA[k*CW +: CW];
               skewB_q[0] <= bus.dataB[k*CW +: CW];
               for (int j = 1; j < k; j++) begin
                  skewA_q[j] <= skewA_q[j-1];
                  skewB_q[j] <= skewB_q[j-1];
               end
            end
         end

         assign stageA[k] = skewA_q[k-1];
         assign stageB[k] = skewB_q[k-1];
         assign validIn   = stageValid[k-1];
         assign carryIn   = stageCarry[k-1];
      end

      pipe_adder_stage #(
         .CW (CW)
      ) u_stage (
         .clk     (clk),
         .reset_L (reset_L),
         .en_i    (advance),
         .valid_i (validIn),
         .a_i     (stageA[k]),
         .b_i     (stageB[k]),
         .carry_i (carryIn),
         .sum_o   (stageSum[k]),
         .carry_o (stageCarry[k]),
         .valid_o (stageValid[k])
      );

      // Lower chunks finish early and wait here until the top chunk of the same transaction lands.
      if (k < STAGES - 1) begin : g_deskew
         localparam int D = STAGES - 1 - k;
         logic [CW-1:0] deskew_q [D];

         always_ff @(posedge clk or negedge reset_L) begin
            if (!reset_L) begin
               for (int j = 0; j < D; j++) begin
                  deskew_q[j] <= '0;
               end
            end else if (advance) begin
               deskew_q[0] <= stageSum[k];
               for (int j = 1; j < D; j++) begin
                  deskew_q[j] <= deskew_q[j-1];
               end
            end
         end

         assign sumAll[k*CW +: CW] = deskew_q[D-1];
      end else begin : g_top
         assign sumAll[k*CW +: CW] = stageSum[k];
      end
   end

   assign bus.out_valid = stageValid[STAGES-1];
   assign bus.sum       = sumAll;
   assign bus.carry_out = stageCarry[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
   // Carry into the MSB is recovered as sumMsb ^ aMsb ^ bMsb, so only aMsb ^ bMsb is kept.
   logic msbXor_q;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         msbXor_q <= 1'b0;
      end else if (advance) begin
         msbXor_q <= stageA[STAGES-1][CW-1] ^ stageB[STAGES-1][CW-1];
      end
   end

   assign bus.ovf = stageCarry[STAGES-1] ^ stageSum[STAGES-1][CW-1] ^ msbXor_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Randomized self-checking bench for pipe_adder against a queue-based arithmetic model.
// Covers the ovf output as well when PIPE_ADDER_OVF_EN is defined.
module tb_pipe_adder;

   logic clk = 1'b0;
   logic reset_L = 1'b0;
   always #5 clk = ~clk;

   pipe_adder_if #(.WIDTH(8)) bus ();
   pipe_adder_if #(.WIDTH(4)) sbus ();

   pipe_adder #(.WIDTH(8), .STAGES(4)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   pipe_adder #(.WIDTH(4), .STAGES(2)) dutSmall (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (sbus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [8:0] expQ[$];
   logic [8:0] gotQ[$];
   int         accQ[$];
   int         gotCycQ[$];

   function automatic logic [8:0] refSum(input logic [7:0] a, input logic [7:0] b, input logic c);
      int s;
      s = int'(a) + int'(b) + int'(c);
      return 9'(s);
   endfunction

   function automatic logic refOvf(input logic [7:0] a, input logic [7:0] b, input logic c);
      int sa, sb, s;
      sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
      sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
      s  = sa + sb + int'(c);
      return (s > 127) || (s < -128);
   endfunction

   task automatic clearModel();
      expQ.delete();
      gotQ.delete();
      accQ.delete();
      gotCycQ.delete();
   endtask

   task automatic driveRandom(input logic valid);
      bus.in_valid = valid;
      bus.dataA    = 8'($urandom);
      bus.dataB    = 8'($urandom);
      bus.carry_in = 1'($urandom);
   endtask

   // Records accepted operands and delivered results for the cycle, then crosses one clock edge.
   task automatic tick();
      #1;
      if (bus.in_valid && bus.in_ready) begin
         expQ.push_back(refSum(bus.dataA, bus.dataB, bus.carry_in));
         accQ.push_back(cyc);
      end
      if (bus.out_valid && bus.out_ready) begin
         gotQ.push_back({bus.carry_out, bus.sum});
         gotCycQ.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(input int maxCycles);
      int n = 0;
      bus.in_valid = 1'b0;
      while (gotQ.size() < expQ.size() && n < maxCycles) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset_L        = 1'b0;
      bus.in_valid   = 1'b0;
      bus.dataA      = '0;
      bus.dataB      = '0;
      bus.carry_in   = 1'b0;
      bus.out_ready  = 1'b0;
      sbus.in_valid  = 1'b0;
      sbus.dataA     = '0;
      sbus.dataB     = '0;
      sbus.carry_in  = 1'b0;
      sbus.out_ready = 1'b1;
      #2;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.sum !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_sum: got %h expected 00", bus.sum);
      end
      checks++;
      if (bus.carry_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_carry_out: got %b expected 0", bus.carry_out);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      checks++;
      if (sbus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_small_out_valid: got %b expected 0", sbus.out_valid);
      end
      repeat (3) @(posedge clk);
      #3;
      reset_L       = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_small_boundary();
      sbus.dataA    = 4'hF;
      sbus.dataB    = 4'h1;
      sbus.carry_in = 1'b0;
      sbus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      sbus.in_valid = 1'b0;
      checks++;
      if (sbus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL small_early_valid: got %b expected 0", sbus.out_valid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (sbus.out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL small_out_valid: got %b expected 1", sbus.out_valid);
      end
      checks++;
      if (sbus.sum !== 4'h0) begin
         errors++;
         $display("[TB] FAIL small_sum: got %h expected 0", sbus.sum);
      end
      checks++;
      if (sbus.carry_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL small_carry_out: got %b expected 1", sbus.carry_out);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int n;
      clearModel();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         driveRandom(1'b1);
         tick();
      end
      drain(40);
      checks++;
      if (gotQ.size() != 16 || expQ.size() != 16) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d results for %0d accepted, expected 16", gotQ.size(), expQ.size());
      end
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (gotQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, gotQ[i], expQ[i]);
         end
         checks++;
         if (gotCycQ[i] - accQ[i] != 4) begin
            errors++;
            $display("[TB] FAIL b2b_latency[%0d]: got %0d expected 4", i, gotCycQ[i] - accQ[i]);
         end
         if (i > 0) begin
            checks++;
            if (gotCycQ[i] != gotCycQ[i-1] + 1) begin
               errors++;
               $display("[TB] FAIL b2b_gap[%0d]: got cycle %0d expected %0d", i, gotCycQ[i], gotCycQ[i-1] + 1);
            end
         end
      end
   endtask

   task automatic test_stall();
      int n;
      clearModel();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         driveRandom(1'b1);
         tick();
      end
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         driveRandom(1'b1);
         #1;
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready);
         end
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_out_valid[%0d]: got %b expected 1", i, bus.out_valid);
         end
         checks++;
         if (expQ.size() == 0 || {bus.carry_out, bus.sum} !== expQ[0]) begin
            errors++;
            $display("[TB] FAIL stall_hold[%0d]: got %h expected %h", i, {bus.carry_out, bus.sum},
                     (expQ.size() > 0) ? expQ[0] : 9'h0);
         end
         tick();
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         driveRandom(1'b1);
         tick();
      end
      drain(40);
      checks++;
      if (expQ.size() != 7 || gotQ.size() != 7) begin
         errors++;
         $display("[TB] FAIL stall_count: got %0d results for %0d accepted, expected 7", gotQ.size(), expQ.size());
      end
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (gotQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL stall_result[%0d]: got %h expected %h", i, gotQ[i], expQ[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int n;
      clearModel();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         driveRandom(1'b1);
         tick();
      end
      bus.in_valid = 1'b0;
      reset_L = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midreset_out_valid: got %b expected 0", bus.out_valid);
      end
      checks++;
      if (bus.sum !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midreset_sum: got %h expected 00", bus.sum);
      end
      checks++;
      if (gotQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL midreset_early_result: got %0d results expected 0", gotQ.size());
      end
      clearModel();
      #2;
      reset_L = 1'b1;
      for (int i = 0; i < 2; i++) begin
         driveRandom(1'b1);
         tick();
      end
      drain(20);
      repeat (6) tick();
      checks++;
      if (gotQ.size() != 2 || expQ.size() != 2) begin
         errors++;
         $display("[TB] FAIL midreset_count: got %0d results for %0d accepted, expected 2", gotQ.size(), expQ.size());
      end
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (gotQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL midreset_result[%0d]: got %h expected %h", i, gotQ[i], expQ[i]);
         end
      end
   endtask

   task automatic test_bubbles();
      logic inPat [20];
      logic outPat [20];
      logic expV;
      int   n;
      clearModel();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         driveRandom((i < 16) && (i % 2 == 0));
         #1;
         inPat[i]  = bus.in_valid;
         outPat[i] = bus.out_valid;
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         expV = (i >= 4) ? inPat[i-4] : 1'b0;
         checks++;
         if (outPat[i] !== expV) begin
            errors++;
            $display("[TB] FAIL bubble_valid[%0d]: got %b expected %b", i, outPat[i], expV);
         end
      end
      checks++;
      if (gotQ.size() != 8 || expQ.size() != 8) begin
         errors++;
         $display("[TB] FAIL bubble_count: got %0d results for %0d accepted, expected 8", gotQ.size(), expQ.size());
      end
      n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         if (gotQ[i] !== expQ[i]) begin
            errors++;
            $display("[TB] FAIL bubble_result[%0d]: got %h expected %h", i, gotQ[i], expQ[i]);
         end
      end
   endtask

`ifdef PIPE_ADDER_OVF_EN
   task automatic test_ovf();
      logic [7:0] va [10];
      logic [7:0] vb [10];
      logic       vc [10];
      logic [8:0] expS;
      logic       expO;
      va[0] = 8'h7F; vb[0] = 8'h01; vc[0] = 1'b0;
      va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0;
      for (int i = 2; i < 10; i++) begin
         va[i] = 8'($urandom);
         vb[i] = 8'($urandom);
         vc[i] = 1'($urandom);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         clearModel();
         bus.in_valid = 1'b1;
         bus.dataA    = va[i];
         bus.dataB    = vb[i];
         bus.carry_in = vc[i];
         tick();
         bus.in_valid = 1'b0;
         repeat (3) tick();
         expS = refSum(va[i], vb[i], vc[i]);
         expO = refOvf(va[i], vb[i], vc[i]);
         checks++;
         if (bus.out_valid !== 1'b1 || {bus.carry_out, bus.sum} !== expS) begin
            errors++;
            $display("[TB] FAIL ovf_sum[%0d]: got valid=%b %h expected valid=1 %h", i, bus.out_valid,
                     {bus.carry_out, bus.sum}, expS);
         end
         checks++;
         if (bus.ovf !== expO) begin
            errors++;
            $display("[TB] FAIL ovf_flag[%0d]: got %b expected %b", i, bus.ovf, expO);
         end
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_small_boundary();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_bubbles();
`ifdef PIPE_ADDER_OVF_EN
      test_ovf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
